// File: rtl/ctrl_pipe_hazard.sv
// Control-path pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall insertion,
// taken-branch flush and saturating stall/flush event counters.
module ctrl_pipe_hazard #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_RegWrite_i,
    input  logic [ALU_OP_W-1:0]   id_ALU_op_i,
    input  logic                  id_ALUSrc_i,
    input  logic                  id_RegDst_i,
    input  logic                  id_Branch_i,
    input  logic                  id_MemWrite_i,
    input  logic                  id_MemRead_i,
    input  logic                  id_MemtoReg_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  ex_zero_i,
    output logic                  ex_RegWrite_o,
    output logic [ALU_OP_W-1:0]   ex_ALU_op_o,
    output logic                  ex_ALUSrc_o,
    output logic                  ex_RegDst_o,
    output logic                  ex_Branch_o,
    output logic                  ex_MemWrite_o,
    output logic                  ex_MemRead_o,
    output logic                  ex_MemtoReg_o,
    output logic                  mem_RegWrite_o,
    output logic                  mem_MemWrite_o,
    output logic                  mem_MemRead_o,
    output logic                  mem_MemtoReg_o,
    output logic                  wb_RegWrite_o,
    output logic                  wb_MemtoReg_o,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  pc_src_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    // ID/EX control register
    logic                  ex_reg_write_q, ex_reg_write_d;
    logic [ALU_OP_W-1:0]   ex_alu_op_q, ex_alu_op_d;
    logic                  ex_alu_src_q, ex_alu_src_d;
    logic                  ex_reg_dst_q, ex_reg_dst_d;
    logic                  ex_branch_q, ex_branch_d;
    logic                  ex_mem_write_q, ex_mem_write_d;
    logic                  ex_mem_read_q, ex_mem_read_d;
    logic                  ex_mem_to_reg_q, ex_mem_to_reg_d;
    logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;

    // EX/MEM control register
    logic mem_reg_write_q, mem_reg_write_d;
    logic mem_mem_write_q, mem_mem_write_d;
    logic mem_mem_read_q, mem_mem_read_d;
    logic mem_mem_to_reg_q, mem_mem_to_reg_d;

    // MEM/WB control register
    logic wb_reg_write_q, wb_reg_write_d;
    logic wb_mem_to_reg_q, wb_mem_to_reg_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic take;
    logic rt_match;
    logic luse;
    logic bubble;

    // A taken branch wins over a load-use hazard: the instruction in ID is wrong-path anyway.
    always_comb begin
        take     = ex_branch_q & ex_zero_i;
        rt_match = (ex_rt_q == id_rs_i) | (ex_rt_q == id_rt_i);
        luse     = ex_mem_read_q & (ex_rt_q != '0) & rt_match & ~take;
        bubble   = take | luse;
    end

    always_comb begin
        ex_reg_write_d  = 1'b0;
        ex_alu_op_d     = '0;
        ex_alu_src_d    = 1'b0;
        ex_reg_dst_d    = 1'b0;
        ex_branch_d     = 1'b0;
        ex_mem_write_d  = 1'b0;
        ex_mem_read_d   = 1'b0;
        ex_mem_to_reg_d = 1'b0;
        ex_rt_d         = '0;
        if (!bubble) begin
            ex_reg_write_d  = id_RegWrite_i;
            ex_alu_op_d     = id_ALU_op_i;
            ex_alu_src_d    = id_ALUSrc_i;
            ex_reg_dst_d    = id_RegDst_i;
            ex_branch_d     = id_Branch_i;
            ex_mem_write_d  = id_MemWrite_i;
            ex_mem_read_d   = id_MemRead_i;
            ex_mem_to_reg_d = id_MemtoReg_i;
            ex_rt_d         = id_rt_i;
        end
    end

    always_comb begin
        mem_reg_write_d  = ex_reg_write_q;
        mem_mem_write_d  = ex_mem_write_q;
        mem_mem_read_d   = ex_mem_read_q;
        mem_mem_to_reg_d = ex_mem_to_reg_q;
        wb_reg_write_d   = mem_reg_write_q;
        wb_mem_to_reg_d  = mem_mem_to_reg_q;
    end

    // Event counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (luse && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (take && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_reg_write_q   <= 1'b0;
            ex_alu_op_q      <= '0;
            ex_alu_src_q     <= 1'b0;
            ex_reg_dst_q     <= 1'b0;
            ex_branch_q      <= 1'b0;
            ex_mem_write_q   <= 1'b0;
            ex_mem_read_q    <= 1'b0;
            ex_mem_to_reg_q  <= 1'b0;
            ex_rt_q          <= '0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= 1'b0;
            stall_cnt_q      <= '0;
            flush_cnt_q      <= '0;
        end else begin
            ex_reg_write_q   <= ex_reg_write_d;
            ex_alu_op_q      <= ex_alu_op_d;
            ex_alu_src_q     <= ex_alu_src_d;
            ex_reg_dst_q     <= ex_reg_dst_d;
            ex_branch_q      <= ex_branch_d;
            ex_mem_write_q   <= ex_mem_write_d;
            ex_mem_read_q    <= ex_mem_read_d;
            ex_mem_to_reg_q  <= ex_mem_to_reg_d;
            ex_rt_q          <= ex_rt_d;
            mem_reg_write_q  <= mem_reg_write_d;
            mem_mem_write_q  <= mem_mem_write_d;
            mem_mem_read_q   <= mem_mem_read_d;
            mem_mem_to_reg_q <= mem_mem_to_reg_d;
            wb_reg_write_q   <= wb_reg_write_d;
            wb_mem_to_reg_q  <= wb_mem_to_reg_d;
            stall_cnt_q      <= stall_cnt_d;
            flush_cnt_q      <= flush_cnt_d;
        end
    end

    always_comb begin
        ex_RegWrite_o  = ex_reg_write_q;
        ex_ALU_op_o    = ex_alu_op_q;
        ex_ALUSrc_o    = ex_alu_src_q;
        ex_RegDst_o    = ex_reg_dst_q;
        ex_Branch_o    = ex_branch_q;
        ex_MemWrite_o  = ex_mem_write_q;
        ex_MemRead_o   = ex_mem_read_q;
        ex_MemtoReg_o  = ex_mem_to_reg_q;
        mem_RegWrite_o = mem_reg_write_q;
        mem_MemWrite_o = mem_mem_write_q;
        mem_MemRead_o  = mem_mem_read_q;
        mem_MemtoReg_o = mem_mem_to_reg_q;
        wb_RegWrite_o  = wb_reg_write_q;
        wb_MemtoReg_o  = wb_mem_to_reg_q;
        pc_write_o     = ~luse;
        ifid_write_o   = ~luse;
        ifid_flush_o   = take;
        pc_src_o       = take;
        stall_cnt_o    = stall_cnt_q;
        flush_cnt_o    = flush_cnt_q;
    end

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard: a default instance plus a CNT_W=2 instance
// sharing the same stimulus so counter saturation can be observed.
module tb_ctrl_pipe_hazard;

    logic       clk;
    logic       rst_n;
    logic       id_reg_write, id_alu_src, id_reg_dst, id_branch;
    logic       id_mem_write, id_mem_read, id_mem_to_reg;
    logic [2:0] id_alu_op;
    logic [4:0] id_rs, id_rt;
    logic       ex_zero;

    logic        ex_reg_write, ex_alu_src, ex_reg_dst, ex_branch;
    logic        ex_mem_write, ex_mem_read, ex_mem_to_reg;
    logic [2:0]  ex_alu_op;
    logic        mem_reg_write, mem_mem_write, mem_mem_read, mem_mem_to_reg;
    logic        wb_reg_write, wb_mem_to_reg;
    logic        pc_write, ifid_write, ifid_flush, pc_src;
    logic [15:0] stall_cnt, flush_cnt;

    logic        d2_ex_reg_write, d2_ex_alu_src, d2_ex_reg_dst, d2_ex_branch;
    logic        d2_ex_mem_write, d2_ex_mem_read, d2_ex_mem_to_reg;
    logic [2:0]  d2_ex_alu_op;
    logic        d2_mem_reg_write, d2_mem_mem_write, d2_mem_mem_read, d2_mem_mem_to_reg;
    logic        d2_wb_reg_write, d2_wb_mem_to_reg;
    logic        d2_pc_write, d2_ifid_write, d2_ifid_flush, d2_pc_src;
    logic [1:0]  d2_stall_cnt, d2_flush_cnt;

    int checks   = 0;
    int failures = 0;

    ctrl_pipe_hazard dut (
        .clk_i(clk), .rst_i(rst_n),
        .id_RegWrite_i(id_reg_write), .id_ALU_op_i(id_alu_op), .id_ALUSrc_i(id_alu_src),
        .id_RegDst_i(id_reg_dst), .id_Branch_i(id_branch), .id_MemWrite_i(id_mem_write),
        .id_MemRead_i(id_mem_read), .id_MemtoReg_i(id_mem_to_reg),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .ex_zero_i(ex_zero),
        .ex_RegWrite_o(ex_reg_write), .ex_ALU_op_o(ex_alu_op), .ex_ALUSrc_o(ex_alu_src),
        .ex_RegDst_o(ex_reg_dst), .ex_Branch_o(ex_branch), .ex_MemWrite_o(ex_mem_write),
        .ex_MemRead_o(ex_mem_read), .ex_MemtoReg_o(ex_mem_to_reg),
        .mem_RegWrite_o(mem_reg_write), .mem_MemWrite_o(mem_mem_write),
        .mem_MemRead_o(mem_mem_read), .mem_MemtoReg_o(mem_mem_to_reg),
        .wb_RegWrite_o(wb_reg_write), .wb_MemtoReg_o(wb_mem_to_reg),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
        .pc_src_o(pc_src), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    ctrl_pipe_hazard #(.CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst_n),
        .id_RegWrite_i(id_reg_write), .id_ALU_op_i(id_alu_op), .id_ALUSrc_i(id_alu_src),
        .id_RegDst_i(id_reg_dst), .id_Branch_i(id_branch), .id_MemWrite_i(id_mem_write),
        .id_MemRead_i(id_mem_read), .id_MemtoReg_i(id_mem_to_reg),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .ex_zero_i(ex_zero),
        .ex_RegWrite_o(d2_ex_reg_write), .ex_ALU_op_o(d2_ex_alu_op), .ex_ALUSrc_o(d2_ex_alu_src),
        .ex_RegDst_o(d2_ex_reg_dst), .ex_Branch_o(d2_ex_branch), .ex_MemWrite_o(d2_ex_mem_write),
        .ex_MemRead_o(d2_ex_mem_read), .ex_MemtoReg_o(d2_ex_mem_to_reg),
        .mem_RegWrite_o(d2_mem_reg_write), .mem_MemWrite_o(d2_mem_mem_write),
        .mem_MemRead_o(d2_mem_mem_read), .mem_MemtoReg_o(d2_mem_mem_to_reg),
        .wb_RegWrite_o(d2_wb_reg_write), .wb_MemtoReg_o(d2_wb_mem_to_reg),
        .pc_write_o(d2_pc_write), .ifid_write_o(d2_ifid_write), .ifid_flush_o(d2_ifid_flush),
        .pc_src_o(d2_pc_src), .stall_cnt_o(d2_stall_cnt), .flush_cnt_o(d2_flush_cnt)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic set_id(input logic rw, input logic [2:0] op, input logic src,
                          input logic dst, input logic br, input logic mw,
                          input logic mr, input logic m2r,
                          input logic [4:0] rs, input logic [4:0] rt);
        id_reg_write  = rw;
        id_alu_op     = op;
        id_alu_src    = src;
        id_reg_dst    = dst;
        id_branch     = br;
        id_mem_write  = mw;
        id_mem_read   = mr;
        id_mem_to_reg = m2r;
        id_rs         = rs;
        id_rt         = rt;
        #1;
    endtask

    task automatic set_nop();
        set_id(0, 3'b000, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    endtask

    task automatic set_add(input logic [4:0] rs, input logic [4:0] rt);
        set_id(1, 3'b010, 0, 1, 0, 0, 0, 0, rs, rt);
    endtask

    task automatic set_lw(input logic [4:0] rt);
        set_id(1, 3'b000, 1, 0, 0, 0, 1, 1, 5'd1, rt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        ex_zero = 1'b0;
        set_nop();
        #12;
        chk("rst_ex_regwrite", {31'd0, ex_reg_write}, 32'd0);
        chk("rst_pc_write", {31'd0, pc_write}, 32'd1);
        chk("rst_ifid_write", {31'd0, ifid_write}, 32'd1);
        chk("rst_flush_pcsrc", {30'd0, ifid_flush, pc_src}, 32'd0);
        chk("rst_counters", {stall_cnt, flush_cnt}, 32'd0);
        step();
        rst_n = 1'b1;

        // R-type latency through ex/mem/wb
        set_add(5'd1, 5'd2);
        step();
        chk("rtype_ex_aluop", {29'd0, ex_alu_op}, 32'd2);
        chk("rtype_ex_regdst_rw", {30'd0, ex_reg_dst, ex_reg_write}, 32'd3);
        set_nop();
        step();
        chk("rtype_mem_rw", {31'd0, mem_reg_write}, 32'd1);
        chk("rtype_ex_cleared", {31'd0, ex_reg_write}, 32'd0);
        step();
        chk("rtype_wb_rw", {31'd0, wb_reg_write}, 32'd1);
        chk("rtype_mem_cleared", {31'd0, mem_reg_write}, 32'd0);

        // Load-use on rs
        set_lw(5'd8);
        step();
        chk("lw_ex_memread", {31'd0, ex_mem_read}, 32'd1);
        set_add(5'd8, 5'd3);
        chk("luse_pc_write", {31'd0, pc_write}, 32'd0);
        chk("luse_ifid_write", {31'd0, ifid_write}, 32'd0);
        step();
        chk("luse_bubble", {25'd0, ex_reg_write, ex_alu_op, ex_reg_dst, ex_mem_read, ex_alu_src}, 32'd0);
        chk("luse_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        chk("luse_mem_memread", {31'd0, mem_mem_read}, 32'd1);
        chk("luse_released", {30'd0, pc_write, ifid_write}, 32'd3);
        step();
        chk("luse_add_in_ex", {28'd0, ex_alu_op, ex_reg_dst}, 32'h5);
        chk("luse_cnt_hold", {16'd0, stall_cnt}, 32'd1);

        // Load-use on rt
        set_lw(5'd5);
        step();
        set_add(5'd0, 5'd5);
        chk("luse_rt_pc_write", {31'd0, pc_write}, 32'd0);
        step();
        chk("luse_rt_stall_cnt", {16'd0, stall_cnt}, 32'd2);

        // lw to $0 never stalls
        set_lw(5'd0);
        step();
        set_add(5'd0, 5'd0);
        chk("r0_no_stall", {31'd0, pc_write}, 32'd1);
        step();
        chk("r0_add_in_ex", {29'd0, ex_alu_op}, 32'd2);
        chk("r0_stall_cnt", {16'd0, stall_cnt}, 32'd2);

        // Taken branch
        set_id(0, 3'b001, 0, 0, 1, 0, 0, 0, 5'd1, 5'd2);
        step();
        chk("beq_in_ex", {31'd0, ex_branch}, 32'd1);
        ex_zero = 1'b1;
        set_add(5'd3, 5'd4);
        chk("take_pcsrc_flush", {30'd0, pc_src, ifid_flush}, 32'd3);
        step();
        ex_zero = 1'b0;
        chk("take_bubble", {27'd0, ex_reg_write, ex_alu_op, ex_branch}, 32'd0);
        chk("take_flush_cnt", {16'd0, flush_cnt}, 32'd1);

        // Not-taken branch
        set_id(0, 3'b001, 0, 0, 1, 0, 0, 0, 5'd1, 5'd2);
        step();
        set_add(5'd3, 5'd4);
        chk("nt_pcsrc_flush", {30'd0, pc_src, ifid_flush}, 32'd0);
        step();
        chk("nt_add_in_ex", {29'd0, ex_alu_op}, 32'd2);
        chk("nt_flush_cnt", {16'd0, flush_cnt}, 32'd1);

        // Illegal branch+load in EX with rt hazard: counts as flush only
        set_id(0, 3'b001, 1, 0, 1, 0, 1, 0, 5'd1, 5'd6);
        step();
        ex_zero = 1'b1;
        set_add(5'd6, 5'd7);
        chk("prio_pc_write", {31'd0, pc_write}, 32'd1);
        chk("prio_flush", {31'd0, ifid_flush}, 32'd1);
        step();
        ex_zero = 1'b0;
        chk("prio_counts", {stall_cnt, flush_cnt}, {16'd2, 16'd2});

        // Five more load-use pairs: wide counter reaches 7, 2-bit counter sticks at 3
        for (int k = 0; k < 5; k++) begin
            set_lw(5'd9);
            step();
            set_add(5'd9, 5'd1);
            step();
            step();
        end
        chk("sat_wide_stall", {16'd0, stall_cnt}, 32'd7);
        chk("sat_narrow_stall", {30'd0, d2_stall_cnt}, 32'd3);
        chk("sat_narrow_flush", {30'd0, d2_flush_cnt}, 32'd2);

        // Asynchronous reset mid-stream
        set_lw(5'd4);
        step();
        set_nop();
        step();
        chk("pre_rst_mem_memread", {31'd0, mem_mem_read}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ex", {25'd0, ex_reg_write, ex_alu_op, ex_mem_read, ex_mem_to_reg, ex_alu_src}, 32'd0);
        chk("arst_mem", {28'd0, mem_reg_write, mem_mem_write, mem_mem_read, mem_mem_to_reg}, 32'd0);
        chk("arst_wb", {30'd0, wb_reg_write, wb_mem_to_reg}, 32'd0);
        chk("arst_counters", {stall_cnt, flush_cnt}, 32'd0);
        chk("arst_narrow_counters", {28'd0, d2_stall_cnt, d2_flush_cnt}, 32'd0);
        chk("arst_pc_write", {31'd0, pc_write}, 32'd1);
        step();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
